// File: rtl/kbd_codes.sv
// Shared scancode constants, FSM encoding and tracked-key table for the
// PS/2 set-2 hotkey detector.
package kbd_codes;

  localparam logic [7:0] PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PREFIX_BRK   = 8'hF0;
  localparam logic [7:0] PREFIX_PAUSE = 8'hE1;

  localparam logic [7:0] KC_CTRL = 8'h14;
  localparam logic [7:0] KC_ALT  = 8'h11;
  localparam logic [7:0] KC_SCRL = 8'h7E;
  localparam logic [7:0] KC_DEL  = 8'h71;
  localparam logic [7:0] KC_BKSP = 8'h66;
  localparam logic [7:0] KC_F5   = 8'h03;

  localparam logic [7:0] KB_BAT_OK   = 8'hAA;
  localparam logic [7:0] KB_ACK      = 8'hFA;
  localparam logic [7:0] KB_RESEND   = 8'hFE;
  localparam logic [7:0] KB_OVERRUN0 = 8'h00;
  localparam logic [7:0] KB_OVERRUN1 = 8'hFF;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_EXT  = 3'd1;
  localparam logic [2:0] ST_BRK  = 3'd2;
  localparam logic [2:0] ST_EBRK = 3'd3;
  localparam logic [2:0] ST_SKIP = 3'd4;

  // Tracked keys, identified as {ext, code}.
  localparam int K_LCTRL = 0;
  localparam int K_RCTRL = 1;
  localparam int K_LALT  = 2;
  localparam int K_RALT  = 3;
  localparam int K_SCRL  = 4;
  localparam int K_DEL   = 5;
  localparam int K_BKSP  = 6;
  localparam int K_F5    = 7;
  localparam int N_KEYS  = 8;

  localparam logic [8:0] KEY_ID [N_KEYS] = '{
    {1'b0, KC_CTRL}, {1'b1, KC_CTRL}, {1'b0, KC_ALT}, {1'b1, KC_ALT},
    {1'b0, KC_SCRL}, {1'b1, KC_DEL},  {1'b0, KC_BKSP}, {1'b0, KC_F5}
  };

endpackage

// File: rtl/pulse_stretcher.sv
// Stretches a one-cycle trigger into a PULSE_LEN-cycle registered high level;
// a retrigger while active reloads the count.
module pulse_stretcher #(
  parameter int PULSE_LEN = 16,
  parameter int PULSE_W   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic q
);

  logic [PULSE_W-1:0] cnt;

  // q is kept equal to (cnt != 0) but comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (trig) begin
      cnt <= PULSE_W'(PULSE_LEN);
      q   <= 1'b1;
    end else begin
      if (cnt != '0) cnt <= cnt - 1'b1;
      q <= (cnt > PULSE_W'(1));
    end
  end

endmodule

// File: rtl/kbd_hotkey_detector.sv
// Decodes PS/2 set-2 scancode bytes into make/break events, tracks modifiers
// and hotkey down state, and fires stretched hotkey pulses on first make.
module kbd_hotkey_detector
  import kbd_codes::*;
#(
  parameter int PULSE_LEN  = 16,
  parameter int PULSE_W    = 5,
  parameter int PAUSE_SKIP = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scancode,
  input  logic       scancode_valid,
  output logic       kbd_change_video_output,
  output logic       soft_reset,
  output logic       master_reset,
  output logic       nmi_req,
  output logic       ctrl_held,
  output logic       alt_held
);

  localparam int SKIP_W = $clog2(PAUSE_SKIP + 1);

  logic [2:0]        state, state_nx;
  logic [SKIP_W-1:0] skip_cnt, skip_nx;
  logic              make_ev, brk_ev, ev_ext, overrun;
  logic [N_KEYS-1:0] key_down;
  logic [8:0]        key_id;

  // NOTE: every signal assigned here gets a default first, so no path
  // through the case statements can infer a latch.
  always_comb begin
    state_nx = state;
    skip_nx  = skip_cnt;
    make_ev  = 1'b0;
    brk_ev   = 1'b0;
    ev_ext   = 1'b0;
    overrun  = 1'b0;
    if (scancode_valid) begin
      case (state)
        ST_IDLE: begin
          case (scancode)
            PREFIX_EXT:   state_nx = ST_EXT;
            PREFIX_BRK:   state_nx = ST_BRK;
            PREFIX_PAUSE: begin
              state_nx = ST_SKIP;
              skip_nx  = SKIP_W'(PAUSE_SKIP);
            end
            KB_OVERRUN0, KB_OVERRUN1:      overrun = 1'b1;
            KB_BAT_OK, KB_ACK, KB_RESEND:  ;
            default:                       make_ev = 1'b1;
          endcase
        end
        ST_EXT: begin
          case (scancode)
            PREFIX_BRK:   state_nx = ST_EBRK;
            PREFIX_EXT:   state_nx = ST_EXT;
            PREFIX_PAUSE: begin
              state_nx = ST_SKIP;
              skip_nx  = SKIP_W'(PAUSE_SKIP);
            end
            default: begin
              make_ev  = 1'b1;
              ev_ext   = 1'b1;
              state_nx = ST_IDLE;
            end
          endcase
        end
        ST_BRK: begin
          brk_ev   = 1'b1;
          state_nx = ST_IDLE;
        end
        ST_EBRK: begin
          brk_ev   = 1'b1;
          ev_ext   = 1'b1;
          state_nx = ST_IDLE;
        end
        ST_SKIP: begin
          if (skip_cnt <= SKIP_W'(1)) state_nx = ST_IDLE;
          else                        skip_nx  = skip_cnt - 1'b1;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  assign key_id = {ev_ext, scancode};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
      key_down <= '0;
    end else begin
      state    <= state_nx;
      skip_cnt <= skip_nx;
      if (overrun) begin
        key_down <= '0;
      end else begin
        for (int i = 0; i < N_KEYS; i++) begin
          if (make_ev && key_id == KEY_ID[i])     key_down[i] <= 1'b1;
          else if (brk_ev && key_id == KEY_ID[i]) key_down[i] <= 1'b0;
        end
      end
    end
  end

  assign ctrl_held = key_down[K_LCTRL] | key_down[K_RCTRL];
  assign alt_held  = key_down[K_LALT]  | key_down[K_RALT];

  // A make of a key already down is auto-repeat and never retriggers.
  logic first_scrl, first_del, first_bksp, first_f5;
  assign first_scrl = make_ev && key_id == KEY_ID[K_SCRL] && !key_down[K_SCRL];
  assign first_del  = make_ev && key_id == KEY_ID[K_DEL]  && !key_down[K_DEL];
  assign first_bksp = make_ev && key_id == KEY_ID[K_BKSP] && !key_down[K_BKSP];
  assign first_f5   = make_ev && key_id == KEY_ID[K_F5]   && !key_down[K_F5];

  logic trig_video, trig_soft, trig_master, trig_nmi;
  assign trig_video  = first_scrl;
  assign trig_soft   = first_del  &&  ctrl_held &&  alt_held;
  assign trig_master = first_bksp &&  ctrl_held &&  alt_held;
  assign trig_nmi    = first_f5   && !ctrl_held && !alt_held;

  pulse_stretcher #(.PULSE_LEN(PULSE_LEN), .PULSE_W(PULSE_W)) u_video (
    .clk(clk), .rst(rst), .trig(trig_video), .q(kbd_change_video_output)
  );
  pulse_stretcher #(.PULSE_LEN(PULSE_LEN), .PULSE_W(PULSE_W)) u_soft (
    .clk(clk), .rst(rst), .trig(trig_soft), .q(soft_reset)
  );
  pulse_stretcher #(.PULSE_LEN(PULSE_LEN), .PULSE_W(PULSE_W)) u_master (
    .clk(clk), .rst(rst), .trig(trig_master), .q(master_reset)
  );
  pulse_stretcher #(.PULSE_LEN(PULSE_LEN), .PULSE_W(PULSE_W)) u_nmi (
    .clk(clk), .rst(rst), .trig(trig_nmi), .q(nmi_req)
  );

endmodule

// File: tb/tb_kbd_hotkey_detector.sv
// Self-checking bench for kbd_hotkey_detector: directed hotkey scenarios plus
// randomized byte streams against a key-state reference model.
module tb_kbd_hotkey_detector;

  localparam int PULSE_LEN = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] scancode;
  logic       scancode_valid;
  logic       kbd_change_video_output, soft_reset, master_reset, nmi_req;
  logic       ctrl_held, alt_held;

  kbd_hotkey_detector #(.PULSE_LEN(PULSE_LEN), .PULSE_W(5), .PAUSE_SKIP(7)) dut (
    .clk(clk), .rst(rst), .scancode(scancode), .scancode_valid(scancode_valid),
    .kbd_change_video_output(kbd_change_video_output), .soft_reset(soft_reset),
    .master_reset(master_reset), .nmi_req(nmi_req),
    .ctrl_held(ctrl_held), .alt_held(alt_held)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every key's up/down state, pending prefixes, skip budget,
  // and remaining high cycles per output (0 video, 1 soft, 2 master, 3 nmi).
  bit m_down [2][256];
  bit m_ext, m_brk;
  int m_skip;
  int m_left [4];

  function automatic bit m_ctrl();
    return m_down[0][8'h14] | m_down[1][8'h14];
  endfunction
  function automatic bit m_alt();
    return m_down[0][8'h11] | m_down[1][8'h11];
  endfunction

  task automatic m_clear_keys();
    for (int e = 0; e < 2; e++)
      for (int c = 0; c < 256; c++) m_down[e][c] = 0;
  endtask

  task automatic m_key(input bit is_make, input bit e, input logic [7:0] c);
    bit ctl, alt, first;
    ctl = m_ctrl();
    alt = m_alt();
    if (!is_make) begin
      m_down[e][int'(c)] = 0;
      return;
    end
    first = !m_down[e][int'(c)];
    m_down[e][int'(c)] = 1;
    if (!first) return;
    if (!e && c == 8'h7E)               m_left[0] = PULSE_LEN;
    if ( e && c == 8'h71 && ctl && alt) m_left[1] = PULSE_LEN;
    if (!e && c == 8'h66 && ctl && alt) m_left[2] = PULSE_LEN;
    if (!e && c == 8'h03 && !ctl && !alt) m_left[3] = PULSE_LEN;
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (m_skip > 0) begin
      m_skip--;
    end else if (m_brk) begin
      m_key(0, m_ext, b);
      m_brk = 0;
      m_ext = 0;
    end else if (m_ext) begin
      if (b == 8'hF0)      m_brk = 1;
      else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hE1) begin m_ext = 0; m_skip = 7; end
      else begin m_key(1, 1, b); m_ext = 0; end
    end else begin
      if (b == 8'hE0)                     m_ext = 1;
      else if (b == 8'hF0)                m_brk = 1;
      else if (b == 8'hE1)                m_skip = 7;
      else if (b == 8'h00 || b == 8'hFF)  m_clear_keys();
      else if (b == 8'hAA || b == 8'hFA || b == 8'hFE) ;
      else                                m_key(1, 0, b);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (m_left[i] > 0) m_left[i]--;
    if (rst) begin
      m_clear_keys();
      m_ext = 0; m_brk = 0; m_skip = 0;
      for (int i = 0; i < 4; i++) m_left[i] = 0;
    end else if (scancode_valid) begin
      m_byte(scancode);
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("video",     32'(kbd_change_video_output), 32'(m_left[0] > 0));
      check("soft",      32'(soft_reset),              32'(m_left[1] > 0));
      check("master",    32'(master_reset),            32'(m_left[2] > 0));
      check("nmi",       32'(nmi_req),                 32'(m_left[3] > 0));
      check("ctrl_held", 32'(ctrl_held),               32'(m_ctrl()));
      check("alt_held",  32'(alt_held),                32'(m_alt()));
    end
  end

  // Rising-edge counters for the literal expectations.
  int rises [4];
  logic [3:0] prev_out = '0;
  always @(negedge clk) begin
    logic [3:0] cur;
    cur = {nmi_req, master_reset, soft_reset, kbd_change_video_output};
    for (int i = 0; i < 4; i++) if (cur[i] && !prev_out[i]) rises[i]++;
    prev_out = cur;
  end

  task automatic send(input logic [7:0] b);
    scancode       = b;
    scancode_valid = 1'b1;
    @(negedge clk);
    scancode_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_rises();
    #1;
    for (int i = 0; i < 4; i++) rises[i] = 0;
  endtask

  task automatic check_rises(input string name, input int v, input int s, input int m, input int n);
    #1;
    check({name, "_video_rises"},  32'(rises[0]), 32'(v));
    check({name, "_soft_rises"},   32'(rises[1]), 32'(s));
    check({name, "_master_rises"}, 32'(rises[2]), 32'(m));
    check({name, "_nmi_rises"},    32'(rises[3]), 32'(n));
  endtask

  initial begin
    int hi;
    int sel;
    logic [7:0] b;
    rst = 1'b1;
    scancode = 8'h00;
    scancode_valid = 1'b0;
    @(negedge clk);
    chk_en = 1;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_outputs", 32'({kbd_change_video_output, soft_reset, master_reset,
                              nmi_req, ctrl_held, alt_held}), 32'(0));

    // Scroll Lock: one pulse of exactly PULSE_LEN cycles.
    clear_rises();
    send(8'h7E);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (kbd_change_video_output) hi++;
      @(negedge clk);
    end
    check("scrl_len", 32'(hi), 32'(16));
    send(8'hF0); send(8'h7E);
    idle(20);
    check_rises("scrl", 1, 0, 0, 0);

    // Auto-repeat suppression, then a fresh make after break.
    clear_rises();
    send(8'h7E); send(8'h7E); send(8'h7E); send(8'hF0); send(8'h7E);
    idle(20);
    send(8'h7E);
    idle(20);
    check_rises("repeat", 2, 0, 0, 0);

    // Ctrl+Alt+Del, then keypad period must not fire.
    clear_rises();
    send(8'h14); send(8'h11); send(8'hE0); send(8'h71);
    #1;
    check("cad_soft_now", 32'(soft_reset), 32'(1));
    idle(20);
    send(8'h71);
    idle(20);
    check_rises("cad", 0, 1, 0, 0);
    send(8'hF0); send(8'h71); send(8'hE0); send(8'hF0); send(8'h71);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h11);
    #1;
    check("cad_ctrl_released", 32'(ctrl_held), 32'(0));

    // Right Ctrl release leaves left Ctrl held; Ctrl+Alt+Backspace.
    clear_rises();
    send(8'hE0); send(8'h14); send(8'h14); send(8'hE0); send(8'hF0); send(8'h14);
    #1;
    check("lctrl_still_held", 32'(ctrl_held), 32'(1));
    send(8'h11); send(8'h66);
    idle(20);
    check_rises("cab", 0, 0, 1, 0);
    send(8'h00);
    #1;
    check("overrun_clears", 32'({ctrl_held, alt_held}), 32'(0));

    // Pause sequence swallowed, F5 NMI, then no NMI with Ctrl held.
    clear_rises();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    #1;
    check("pause_no_ctrl", 32'(ctrl_held), 32'(0));
    send(8'h03);
    idle(20);
    send(8'hF0); send(8'h03); send(8'h14); send(8'h03);
    idle(20);
    check_rises("f5", 0, 0, 0, 1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h03);

    // Reset in cycle 5 of a video pulse truncates it and clears held state.
    send(8'h14);
    send(8'h7E);
    idle(4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_truncates", 32'(kbd_change_video_output), 32'(0));
    check("rst_clears_ctrl", 32'(ctrl_held), 32'(0));
    clear_rises();
    send(8'hE0); send(8'h71); send(8'hE0); send(8'hF0); send(8'h71);
    send(8'h14); send(8'h11); send(8'hE0); send(8'h71);
    idle(20);
    check_rises("post_rst", 0, 1, 0, 0);

    // Randomized byte stream biased toward the interesting codes.
    send(8'h00);
    for (int n = 0; n < 3000; n++) begin
      sel = int'($urandom_range(0, 39));
      case (sel)
        0, 1, 2, 3:   b = 8'hE0;
        4, 5, 6, 7:   b = 8'hF0;
        8:            b = 8'hE1;
        9:            b = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
        10:           b = ($urandom_range(0, 1) != 0) ? 8'hAA : 8'hFA;
        11, 12, 13, 14: b = 8'h14;
        15, 16, 17, 18: b = 8'h11;
        19, 20, 21:   b = 8'h7E;
        22, 23, 24:   b = 8'h71;
        25, 26, 27:   b = 8'h66;
        28, 29, 30:   b = 8'h03;
        default:      b = 8'($urandom);
      endcase
      send(b);
      idle(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    idle(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/kbd_hotkey_detector.md
Name: kbd_hotkey_detector

Overview:
- Upstream neighbour of the scandoubler control register.
- Consumes PS/2 set-2 scancode bytes from the keyboard receiver and recognises system hotkeys.
- Produces stretched level pulses: video-mode toggle (Scroll Lock, feeds scandoubler control's kbd_change_video_output), soft reset, master reset and NMI request.
- Tracks prefixes, modifier state and auto-repeat suppression.

Parameters:
- PULSE_LEN, 16: cycles each output stays high once triggered (≥2 so the downstream 2-FF edge detector sees it).
- PULSE_W, 5: width of each pulse counter; must hold PULSE_LEN.
- PAUSE_SKIP, 7: bytes discarded after an E1 prefix (Pause sequence tail).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- scancode  in  8  received PS/2 byte
- scancode_valid  in  1  one-cycle strobe, scancode valid
- kbd_change_video_output  out  1  Scroll Lock make → PULSE_LEN-cycle high pulse
- soft_reset  out  1  Ctrl+Alt+Del (E0 71) make → pulse
- master_reset  out  1  Ctrl+Alt+Backspace (66) make → pulse
- nmi_req  out  1  F5 (03) make, no modifiers → pulse
- ctrl_held  out  1  either Ctrl down
- alt_held  out  1  either Alt down

Behaviour:
- Reset (rst=1 at posedge clk):
  - FSM goes to IDLE.
  - All held flags, down flags, pulse counters and outputs go to 0.
  - rst mid-pulse truncates the pulse on the next cycle.
- Bytes are processed only on cycles with scancode_valid=1. All state updates are registered at that edge.
- FSM states:
  - IDLE
    - E0 → EXT.
    - F0 → BRK.
    - E1 → SKIP, with skip_cnt=PAUSE_SKIP.
    - 00 or FF (overrun) → clear all held/down flags, stay IDLE.
    - AA, FA, FE → ignored, stay IDLE.
    - Any other byte → make event (code, ext=0), stay IDLE.
  - EXT
    - F0 → EBRK.
    - E0 or E1 → stay EXT / go to SKIP (treated as a fresh prefix).
    - Any other byte → make event (code, ext=1) → IDLE.
  - BRK: any byte → break event (code, ext=0) → IDLE.
  - EBRK: any byte → break event (code, ext=1) → IDLE.
  - SKIP: each valid byte decrements skip_cnt; when the count reaches 1 on a valid byte → IDLE. No events are generated.
- Modifier flags:
  - lctrl = 14/ext0, rctrl = 14/ext1.
  - lalt = 11/ext0, ralt = 11/ext1.
  - Make sets the flag, break clears it.
  - ctrl_held = lctrl|rctrl; alt_held = lalt|ralt.
  - Releasing one side does not clear the other.
- Hotkey down flags (scrl_dn 7E/0, del_dn 71/1, bksp_dn 66/0, f5_dn 03/0):
  - A make with the flag already set is auto-repeat and is ignored.
  - A break clears the flag.
- Triggers (first make only):
  - Scroll Lock → kbd_change_video_output. Unconditional.
  - Del ext → soft_reset. Requires ctrl_held & alt_held as sampled before this byte.
  - Backspace → master_reset. Requires ctrl_held & alt_held.
  - F5 → nmi_req. Requires !ctrl_held & !alt_held.
  - Keypad period (71 ext0) must NOT trigger soft_reset.
- Pulse generation:
  - A trigger loads that output's counter with PULSE_LEN.
  - The output equals (counter≠0), registered. It goes high the cycle after the valid byte and stays high exactly PULSE_LEN cycles.
  - The counter decrements every clk, independent of scancode_valid.
  - A retrigger while active reloads the counter (pulse extended, not doubled).
- Outputs are independent. master_reset and soft_reset cannot fire on the same byte.
- Latency is one cycle from the valid byte to ctrl_held/alt_held or pulse rise.

Decomposition:
- Shared package (kbd_codes):
  - Scancode constants: PREFIX_EXT=E0, PREFIX_BRK=F0, PREFIX_PAUSE=E1, KC_CTRL=14, KC_ALT=11, KC_SCRL=7E, KC_DEL=71, KC_BKSP=66, KC_F5=03, plus the BAT/ACK/RESEND/overrun codes.
  - FSM state encoding.
- One natural sub-module, pulse_stretcher (parameter PULSE_LEN; ports clk, rst, trig, q), instantiated four times.

Test Plan:
- After reset, send 7E, F0 7E → kbd_change_video_output high for exactly 16 cycles starting the cycle after the 7E strobe; all other outputs stay 0.
- Send 7E, 7E, 7E (auto-repeat), F0 7E, 7E → exactly two pulses: one for the first make, one for the make after the break.
- Send 14, 11, E0 71 → soft_reset 16-cycle pulse. Then send 71 without E0 (keypad period) → no pulse.
- Send E0 14, 14, E0 F0 14, then 11, 66 → ctrl_held stays 1 after the right-Ctrl release; master_reset pulses.
- Send E1 14 77 E1 F0 14 F0 77, then 03 → no events during the Pause sequence; nmi_req pulses after 03. Then send 14, 03 (with F0 03 between) → no NMI while Ctrl is held.
- Assert rst while kbd_change_video_output is high (cycle 5 of 16) → output low the next cycle; held flags cleared; FSM back in IDLE (verify with E0 71 not misparsed).
